// File: rtl/counter_bank_ltl_pkg.sv
// counter_bank_ltl_pkg: shared types and sizing helpers for the counter bank.
package counter_bank_ltl_pkg;

    typedef enum logic {
        MODE_WRAP,
        MODE_SAT
    } overflow_mode_t;

    // A single channel still gets a 1-bit select so the port never collapses to zero width.
    function automatic int load_ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic logic [63:0] max_count(input int width);
        return (width >= 64) ? '1 : (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/counter_bank_ltl_channel.sv
// counter_bank_ltl_channel: one up-counter with hit pulse, sticky flag and wrap/saturate overflow.
// Embedded properties are compiled only when COUNTER_BANK_LTL_SVA_EN is defined.
module counter_bank_ltl_channel
    import counter_bank_ltl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int TARGET   = 8,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             hit,
    output logic             sticky,
    output logic             wrapped
);

    localparam overflow_mode_t MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH));
    localparam logic [WIDTH-1:0] TGT = WIDTH'(TARGET);

    logic [WIDTH-1:0] count_next;
    logic             at_max;
    logic             hit_next;
    logic             wrapped_next;

    always_comb begin
        at_max       = count == MAX;
        count_next   = clr ? '0
                     : load ? load_value
                     : (inc && !(at_max && MODE == MODE_SAT)) ? count + WIDTH'(1)
                     : count;
        // Comparing against the old count keeps a saturated hold at TARGET from re-firing.
        hit_next     = !clr && count_next == TGT && count != TGT;
        wrapped_next = !clr && !load && inc && at_max && MODE == MODE_WRAP;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            hit     <= 1'b0;
            sticky  <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            count   <= count_next;
            hit     <= hit_next;
            sticky  <= !clr && (sticky || hit_next);
            wrapped <= wrapped_next;
        end
    end

`ifdef COUNTER_BANK_LTL_SVA_EN
    localparam logic [WIDTH-1:0] TGT_M1 = TGT - WIDTH'(1);

    p_sticky: assert property (@(posedge clock) disable iff (!reset_n)
        sticky && !clr |=> sticky);

    // TARGET 0 under saturation is unreachable by stepping, so step/hit only apply otherwise.
    if (TARGET != 0 || MODE == MODE_WRAP) begin : g_step
        p_step: assert property (@(posedge clock) disable iff (!reset_n)
            inc && !clr && !load && count == TGT_M1 |-> nexttime (count == TGT));
        p_hit: assert property (@(posedge clock) disable iff (!reset_n)
            count == TGT_M1 && inc && !clr && !load |=> hit);
    end

    p_no_double_hit: assert property (@(posedge clock) disable iff (!reset_n)
        hit && !load && !clr |=> !hit);

    m_live_inc: assume property (@(posedge clock) disable iff (!reset_n)
        inc && !clr && !load);

    p_live: assert property (@(posedge clock) disable iff (!reset_n)
        s_eventually sticky);
`else
`endif

endmodule

// File: rtl/counter_bank_ltl.sv
// counter_bank_ltl: bank of CHANNELS independent counters with load decode and all_hit.
// Define COUNTER_BANK_LTL_SVA_EN to elaborate the per-channel property sets.
module counter_bank_ltl
    import counter_bank_ltl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int TARGET   = 8,
    parameter int SATURATE = 0
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [CHANNELS-1:0]                  inc,
    input  logic [CHANNELS-1:0]                  clr,
    input  logic                                 load,
    input  logic [load_ch_width(CHANNELS)-1:0]   load_ch,
    input  logic [WIDTH-1:0]                     load_value,
    output logic [CHANNELS*WIDTH-1:0]            count,
    output logic [CHANNELS-1:0]                  hit,
    output logic [CHANNELS-1:0]                  sticky,
    output logic [CHANNELS-1:0]                  wrapped,
    output logic                                 all_hit
);

    localparam int LW = load_ch_width(CHANNELS);

    logic [CHANNELS-1:0] load_sel;

    // Out-of-range load_ch matches no channel, so the load is dropped.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign load_sel[g] = load && load_ch == LW'(g);

        counter_bank_ltl_channel #(
            .WIDTH    (WIDTH),
            .TARGET   (TARGET),
            .SATURATE (SATURATE)
        ) u_channel (
            .clock      (clock),
            .reset_n    (reset_n),
            .inc        (inc[g]),
            .clr        (clr[g]),
            .load       (load_sel[g]),
            .load_value (load_value),
            .count      (count[g*WIDTH +: WIDTH]),
            .hit        (hit[g]),
            .sticky     (sticky[g]),
            .wrapped    (wrapped[g])
        );
    end

    assign all_hit = &sticky;

endmodule

// File: tb/tb_counter_bank_ltl.sv
// tb_counter_bank_ltl: scoreboard bench for a default bank plus 4-bit wrap and saturate banks.
module tb_counter_bank_ltl;

    logic clock = 1'b0;
    logic reset_n = 1'b1;

    logic [3:0]   inc_a = '0, clr_a = '0;
    logic         load_a = 1'b0;
    logic [1:0]   load_ch_a = '0;
    logic [31:0]  lv_a = '0;
    logic [127:0] count_a;
    logic [3:0]   hit_a, sticky_a, wrapped_a;
    logic         all_a;

    logic [2:0]   inc_s = '0, clr_s = '0;
    logic         load_s = 1'b0;
    logic [1:0]   load_ch_s = '0;
    logic [3:0]   lv_s = '0;
    logic [11:0]  count_b, count_c;
    logic [2:0]   hit_b, sticky_b, wrapped_b, hit_c, sticky_c, wrapped_c;
    logic         all_b, all_c;

    always #5 clock = ~clock;

    counter_bank_ltl #(.WIDTH(32), .CHANNELS(4), .TARGET(8), .SATURATE(0)) dut_a (
        .clock(clock), .reset_n(reset_n), .inc(inc_a), .clr(clr_a), .load(load_a),
        .load_ch(load_ch_a), .load_value(lv_a), .count(count_a), .hit(hit_a),
        .sticky(sticky_a), .wrapped(wrapped_a), .all_hit(all_a)
    );

    counter_bank_ltl #(.WIDTH(4), .CHANNELS(3), .TARGET(8), .SATURATE(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .inc(inc_s), .clr(clr_s), .load(load_s),
        .load_ch(load_ch_s), .load_value(lv_s), .count(count_b), .hit(hit_b),
        .sticky(sticky_b), .wrapped(wrapped_b), .all_hit(all_b)
    );

    counter_bank_ltl #(.WIDTH(4), .CHANNELS(3), .TARGET(8), .SATURATE(1)) dut_c (
        .clock(clock), .reset_n(reset_n), .inc(inc_s), .clr(clr_s), .load(load_s),
        .load_ch(load_ch_s), .load_value(lv_s), .count(count_c), .hit(hit_c),
        .sticky(sticky_c), .wrapped(wrapped_c), .all_hit(all_c)
    );

    typedef struct {
        string        tag;
        logic [127:0] ca;
        logic [12:0]  fa;
        logic [11:0]  cb, cc;
        logic [9:0]   fb, fc;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    // Reference state: index 0 = default bank, 1 = 4-bit wrap, 2 = 4-bit saturate.
    longint unsigned mc[3][4];
    bit ms[3][4], mh[3][4], mw[3][4];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 4; c++) begin
                mc[i][c] = 0; ms[i][c] = 0; mh[i][c] = 0; mw[i][c] = 0;
            end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int nch;
            nch = (i == 0) ? 4 : 3;
            for (int c = 0; c < nch; c++) begin
                bit cl, ld, in;
                longint unsigned lv, mx, nw;
                cl = (i == 0) ? clr_a[c] : clr_s[c];
                in = (i == 0) ? inc_a[c] : inc_s[c];
                ld = (i == 0) ? (load_a && load_ch_a == 2'(c)) : (load_s && load_ch_s == 2'(c));
                lv = (i == 0) ? 64'(lv_a) : 64'(lv_s);
                mx = (i == 0) ? 64'hFFFF_FFFF : 64'hF;
                mw[i][c] = 0;
                if (cl) nw = 0;
                else if (ld) nw = lv;
                else if (in && mc[i][c] == mx) begin
                    nw = (i == 2) ? mx : 0;
                    mw[i][c] = (i != 2);
                end
                else if (in) nw = mc[i][c] + 1;
                else nw = mc[i][c];
                mh[i][c] = !cl && nw == 8 && mc[i][c] != 8;
                ms[i][c] = !cl && (ms[i][c] || mh[i][c]);
                mc[i][c] = nw;
            end
        end
    endtask

    function automatic exp_t snapshot(input string tag);
        exp_t e;
        e.tag = tag; e.ca = '0; e.fa = '0; e.cb = '0; e.cc = '0; e.fb = '0; e.fc = '0;
        for (int c = 0; c < 4; c++) begin
            e.ca[32*c +: 32] = mc[0][c][31:0];
            e.fa[c] = mh[0][c]; e.fa[4+c] = ms[0][c]; e.fa[8+c] = mw[0][c];
        end
        e.fa[12] = ms[0][0] & ms[0][1] & ms[0][2] & ms[0][3];
        for (int c = 0; c < 3; c++) begin
            e.cb[4*c +: 4] = mc[1][c][3:0];
            e.cc[4*c +: 4] = mc[2][c][3:0];
            e.fb[c] = mh[1][c]; e.fb[3+c] = ms[1][c]; e.fb[6+c] = mw[1][c];
            e.fc[c] = mh[2][c]; e.fc[3+c] = ms[2][c]; e.fc[6+c] = mw[2][c];
        end
        e.fb[9] = ms[1][0] & ms[1][1] & ms[1][2];
        e.fc[9] = ms[2][0] & ms[2][1] & ms[2][2];
        return e;
    endfunction

    task automatic compare_pop();
        exp_t e;
        if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = q.pop_front();
        check({e.tag, " count_a"}, count_a, e.ca);
        check({e.tag, " flags_a"}, 128'({all_a, wrapped_a, sticky_a, hit_a}), 128'(e.fa));
        check({e.tag, " count_b"}, 128'(count_b), 128'(e.cb));
        check({e.tag, " flags_b"}, 128'({all_b, wrapped_b, sticky_b, hit_b}), 128'(e.fb));
        check({e.tag, " count_c"}, 128'(count_c), 128'(e.cc));
        check({e.tag, " flags_c"}, 128'({all_c, wrapped_c, sticky_c, hit_c}), 128'(e.fc));
    endtask

    task automatic cyc(input string tag);
        model_edge();
        q.push_back(snapshot(tag));
        @(posedge clock);
        #1;
        compare_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        model_reset();
        q.push_back(snapshot("reset"));
        compare_pop();
        reset_n = 1'b1;
        cyc("idle");

        inc_a[0] = 1'b1;
        for (int k = 0; k < 8; k++) cyc($sformatf("inc0_%0d", k));
        inc_a[0] = 1'b0;
        cyc("inc0_hold");

        load_s = 1'b1; load_ch_s = 2'd0; lv_s = 4'd15;
        cyc("ld15");
        load_s = 1'b0; inc_s[0] = 1'b1;
        cyc("ovf");
        cyc("ovf2");
        inc_s[0] = 1'b0;

        load_a = 1'b1; load_ch_a = 2'd2; lv_a = 32'd8;
        cyc("ld2_tgt");
        clr_a[2] = 1'b1; lv_a = 32'd5; inc_a[2] = 1'b1;
        cyc("conflict");
        clr_a[2] = 1'b0;
        cyc("ld_beats_inc");
        load_a = 1'b0; inc_a[2] = 1'b0;

        inc_a[1] = 1'b1;
        repeat (3) cyc("inc1");
        inc_a[1] = 1'b0;
        load_a = 1'b1; load_ch_a = 2'd1; lv_a = 32'd8;
        cyc("ld1_tgt");
        cyc("ld1_tgt_again");
        load_a = 1'b0;

        load_s = 1'b1; load_ch_s = 2'd3; lv_s = 4'd5;
        cyc("ld_oor");
        load_s = 1'b0;

        for (int k = 0; k < 300; k++) begin
            inc_a = 4'($urandom);
            clr_a = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd0;
            load_a = ($urandom_range(0, 5) == 0);
            load_ch_a = 2'($urandom);
            lv_a = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                               : 32'($urandom_range(5, 9));
            inc_s = 3'($urandom);
            clr_s = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'd0;
            load_s = ($urandom_range(0, 5) == 0);
            load_ch_s = 2'($urandom);
            lv_s = 4'($urandom);
            cyc("rand");
        end

        clr_a = '0; clr_s = '0; load_a = 1'b0; load_s = 1'b0;
        inc_a = 4'hF; inc_s = 3'h7;
        cyc("pre_rst");
        reset_n = 1'b0;
        model_reset();
        q.push_back(snapshot("async_rst"));
        #2;
        compare_pop();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
